// File: rtl/ar_dep_check_pipe_if.sv
// Bundle enq/deq handshake bus for the rename-stage AR dependence checker.
interface ar_dep_check_pipe_if #(
  parameter int WAYS      = 4,
  parameter int AR_WIDTH  = 5,
  parameter int SEL_WIDTH = $clog2(WAYS)
);
  logic                               enq_valid;
  logic                               enq_ready;
  logic [WAYS-1:0]                    enq_valid_by_way;
  logic [WAYS-1:0][AR_WIDTH-1:0]      enq_A_AR_by_way;
  logic [WAYS-1:0][AR_WIDTH-1:0]      enq_B_AR_by_way;
  logic [WAYS-1:0]                    enq_regwrite_by_way;
  logic [WAYS-1:0][AR_WIDTH-1:0]      enq_dest_AR_by_way;

  logic                               deq_valid;
  logic                               deq_ready;
  logic [WAYS-1:0]                    deq_valid_by_way;
  logic [WAYS-1:0]                    deq_A_PR_dep_by_way;
  logic [WAYS-1:0]                    deq_B_PR_dep_by_way;
  logic [WAYS-1:0]                    deq_dest_PR_dep_by_way;
  logic [WAYS-1:0][SEL_WIDTH-1:0]     deq_A_PR_sel_by_way;
  logic [WAYS-1:0][SEL_WIDTH-1:0]     deq_B_PR_sel_by_way;
  logic [WAYS-1:0][SEL_WIDTH-1:0]     deq_dest_PR_sel_by_way;
  logic [WAYS-1:0]                    deq_dest_last_by_way;

  modport slave (
    input  enq_valid, enq_valid_by_way, enq_A_AR_by_way, enq_B_AR_by_way,
           enq_regwrite_by_way, enq_dest_AR_by_way, deq_ready,
    output enq_ready, deq_valid, deq_valid_by_way, deq_A_PR_dep_by_way,
           deq_B_PR_dep_by_way, deq_dest_PR_dep_by_way, deq_A_PR_sel_by_way,
           deq_B_PR_sel_by_way, deq_dest_PR_sel_by_way, deq_dest_last_by_way
  );

  modport master (
    output enq_valid, enq_valid_by_way, enq_A_AR_by_way, enq_B_AR_by_way,
           enq_regwrite_by_way, enq_dest_AR_by_way, deq_ready,
    input  enq_ready, deq_valid, deq_valid_by_way, deq_A_PR_dep_by_way,
           deq_B_PR_dep_by_way, deq_dest_PR_dep_by_way, deq_A_PR_sel_by_way,
           deq_B_PR_sel_by_way, deq_dest_PR_sel_by_way, deq_dest_last_by_way
  );
endinterface

// File: rtl/ar_dep_check_pipe.sv
// Intra-bundle RAW/WAW AR dependence checker with registered output + skid buffer.
// Define LOROF_AR_DEP_X0_FILTER_EN to treat AR 0 as the hardwired zero register.

module ar_dep_way #(
  parameter int WAYS      = 4,
  parameter int AR_WIDTH  = 5,
  parameter int SEL_WIDTH = $clog2(WAYS),
  parameter int W         = 0
) (
  input  logic                          vld,
  input  logic [AR_WIDTH-1:0]           a_ar,
  input  logic [AR_WIDTH-1:0]           b_ar,
  input  logic [WAYS-1:0]               eff_wr,
  input  logic [WAYS-1:0][AR_WIDTH-1:0] dest_ar,
  output logic                          a_dep,
  output logic [SEL_WIDTH-1:0]          a_sel,
  output logic                          b_dep,
  output logic [SEL_WIDTH-1:0]          b_sel,
  output logic                          d_dep,
  output logic [SEL_WIDTH-1:0]          d_sel,
  output logic                          last
);
  always_comb begin
    a_dep = 1'b0; a_sel = '0;
    b_dep = 1'b0; b_sel = '0;
    d_dep = 1'b0; d_sel = '0;
    last  = 1'b0;
    if (vld) begin
      // ascending scan: the last hit wins, giving the youngest older producer
      for (int j = 0; j < W; j++) begin
        if (eff_wr[j]) begin
          if (dest_ar[j] == a_ar)       begin a_dep = 1'b1; a_sel = SEL_WIDTH'(j); end
          if (dest_ar[j] == b_ar)       begin b_dep = 1'b1; b_sel = SEL_WIDTH'(j); end
          if (dest_ar[j] == dest_ar[W]) begin d_dep = 1'b1; d_sel = SEL_WIDTH'(j); end
        end
      end
      last = eff_wr[W];
      for (int k = W + 1; k < WAYS; k++) begin
        if (eff_wr[k] && dest_ar[k] == dest_ar[W]) last = 1'b0;
      end
    end
  end
endmodule

module ar_dep_check_pipe #(
  parameter int WAYS      = 4,
  parameter int AR_WIDTH  = 5,
  parameter int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  ar_dep_check_pipe_if.slave    bus
);
  typedef struct packed {
    logic [WAYS-1:0]                vbw;
    logic [WAYS-1:0]                a_dep;
    logic [WAYS-1:0]                b_dep;
    logic [WAYS-1:0]                d_dep;
    logic [WAYS-1:0]                last;
    logic [WAYS-1:0][SEL_WIDTH-1:0] a_sel;
    logic [WAYS-1:0][SEL_WIDTH-1:0] b_sel;
    logic [WAYS-1:0][SEL_WIDTH-1:0] d_sel;
  } res_t;

  logic [WAYS-1:0]                eff_wr;
  logic [WAYS-1:0]                a_dep, b_dep, d_dep, last;
  logic [WAYS-1:0][SEL_WIDTH-1:0] a_sel, b_sel, d_sel;
  res_t                           res;

  res_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic enq_ready, enq_acc;

  always_comb begin
    for (int j = 0; j < WAYS; j++) begin
`ifdef LOROF_AR_DEP_X0_FILTER_EN
      // a zero-register dest is never a real producer
      eff_wr[j] = bus.enq_valid_by_way[j] & bus.enq_regwrite_by_way[j] &
                  (bus.enq_dest_AR_by_way[j] != '0);
`else
      eff_wr[j] = bus.enq_valid_by_way[j] & bus.enq_regwrite_by_way[j];
`endif
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ar_dep_way #(.WAYS(WAYS), .AR_WIDTH(AR_WIDTH), .SEL_WIDTH(SEL_WIDTH), .W(w)) u_way (
      .vld     (bus.enq_valid_by_way[w]),
      .a_ar    (bus.enq_A_AR_by_way[w]),
      .b_ar    (bus.enq_B_AR_by_way[w]),
      .eff_wr  (eff_wr),
      .dest_ar (bus.enq_dest_AR_by_way),
      .a_dep   (a_dep[w]),
      .a_sel   (a_sel[w]),
      .b_dep   (b_dep[w]),
      .b_sel   (b_sel[w]),
      .d_dep   (d_dep[w]),
      .d_sel   (d_sel[w]),
      .last    (last[w])
    );
  end

  always_comb begin
    res       = '0;
    res.vbw   = bus.enq_valid_by_way;
    res.a_dep = a_dep;
    res.b_dep = b_dep;
    res.d_dep = d_dep;
    res.last  = last;
    res.a_sel = a_sel;
    res.b_sel = b_sel;
    res.d_sel = d_sel;
  end

  // ready comes from registered state only, never from deq_ready
  assign enq_ready = ~skid_vld_q & ~flush;
  assign enq_acc   = bus.enq_valid & enq_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || bus.deq_ready) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (enq_acc) begin
        out_d      = res;
        out_vld_d  = 1'b1;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (enq_acc) begin
      skid_d     = res;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.enq_ready              = enq_ready;
  assign bus.deq_valid              = out_vld_q;
  assign bus.deq_valid_by_way       = out_q.vbw;
  assign bus.deq_A_PR_dep_by_way    = out_q.a_dep;
  assign bus.deq_B_PR_dep_by_way    = out_q.b_dep;
  assign bus.deq_dest_PR_dep_by_way = out_q.d_dep;
  assign bus.deq_A_PR_sel_by_way    = out_q.a_sel;
  assign bus.deq_B_PR_sel_by_way    = out_q.b_sel;
  assign bus.deq_dest_PR_sel_by_way = out_q.d_sel;
  assign bus.deq_dest_last_by_way   = out_q.last;
endmodule

// File: doc/ar_dep_check_pipe.md
# ar_dep_check_pipe

Parametrised, pipelined intra-bundle architectural register dependence checker for the rename stage. It accepts a bundle of up to WAYS instructions per cycle through a valid/ready handshake. For each way it computes RAW dependences (A and B sources) and WAW dependences (dest) on older ways in the same bundle, plus a youngest-writer flag used for map table update. Results are presented from a registered output stage backed by a one-entry skid buffer, so `enq_ready` does not depend combinationally on `deq_ready`.

## Interface
- WAYS, 4, instructions per bundle (≥2)
- AR_WIDTH, 5, architectural register index width
- SEL_WIDTH, $clog2(WAYS), width of older-way select
- CLK  input  1  clock, all state on posedge
- nRST  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of output stage and skid buffer
- enq_valid  input  1  bundle offered
- enq_ready  output  1  bundle accepted when enq_valid & enq_ready
- enq_valid_by_way  input  WAYS  per-way valid mask
- enq_A_AR_by_way  input  WAYS×AR_WIDTH  source A AR
- enq_B_AR_by_way  input  WAYS×AR_WIDTH  source B AR
- enq_regwrite_by_way  input  WAYS  way writes dest AR
- enq_dest_AR_by_way  input  WAYS×AR_WIDTH  dest AR
- deq_valid  output  1  result bundle present
- deq_ready  input  1  downstream consumes when deq_valid & deq_ready
- deq_valid_by_way  output  WAYS  pass-through of way mask
- deq_A_PR_dep_by_way / deq_B_PR_dep_by_way / deq_dest_PR_dep_by_way  output  WAYS each  dependence found
- deq_A_PR_sel_by_way / deq_B_PR_sel_by_way / deq_dest_PR_sel_by_way  output  WAYS×SEL_WIDTH each  producing older way
- deq_dest_last_by_way  output  WAYS  way is youngest effective writer of its dest AR in bundle

## Operation
- Effective writer: way j with enq_valid_by_way[j] & enq_regwrite_by_way[j].
- For way w and field F ∈ {A, B, dest}: dep=1 iff some effective writer j<w has dest_AR[j]==F_AR[w]. Full AR_WIDTH compare. sel = highest such j, i.e. youngest older producer.
- No dep: sel=0. Invalid way: dep=0, sel=0, last=0 for all fields.
- Way 0 always dep=0, sel=0.
- dest dep does not require regwrite[w]. It is still computed, and consumers qualify it.
- deq_dest_last_by_way[w]=1 iff w is an effective writer and no effective writer k>w has the same dest AR.
- Results are computed combinationally from enq_* and captured on acceptance. Nothing is recomputed after capture.
- Storage: output register (OUT) and skid register (SKID), each holding a valid bit plus results.
- enq_ready = !SKID.valid & !flush.
- Each edge, with flush=0:
  - OUT empty or deq_ready: OUT loads SKID if SKID.valid (SKID clears), else OUT loads the accepted enq bundle, else OUT goes empty.
  - OUT full and !deq_ready, with an enq accepted: the bundle goes to SKID.
- deq_valid = OUT.valid. Payload outputs are held stable while deq_valid & !deq_ready.
- flush=1: at the next edge OUT.valid=0 and SKID.valid=0. Any enq offered in the flush cycle is not accepted. flush has priority over all handshakes.
- Bundles leave in acceptance order. None is dropped or duplicated except by flush or reset.

## Timing
- Latency: accepted at edge N, visible on deq at N+1 when OUT was empty or being consumed.
- Throughput: one bundle/cycle while deq_ready=1.
- enq_ready depends only on registered state and flush. It has no combinational path from deq_ready.
- Simultaneous deq, SKID occupied, and enq offered: enq_ready=0, and SKID drains to OUT at that edge.
- Reset (nRST=0, any cycle, including mid-transfer): OUT.valid=0, SKID.valid=0, all deq_* payload outputs 0, deq_valid=0, enq_ready=1. In-flight bundles are discarded.

## Configuration
- LOROF_AR_DEP_X0_FILTER_EN defined:
  - AR 0 is the hardwired zero register.
  - A source AR of 0 never sets A or B dep.
  - A way with dest AR 0 is not an effective writer, so it never produces a dep, and its dest dep=0 and last=0.
- Undefined: AR 0 is compared like any other index.

## Test plan
- WAYS=4, empty pipe, deq_ready=1. Ways 0..3 all regwrite with dest AR 5. Way 3 A=5, B=7. -> Next cycle: deq_A dep[3]=1 sel=2, B dep[3]=0. dest dep[1..3]=1 with sel 0,1,2. last=4'b1000.
- Same dest AR 5 bundle but enq_valid_by_way=4'b1011. -> Way 3 A sel=1, since way 2 is masked. last=4'b1000, dep/sel for way 2 all 0.
- deq_ready=0 for 3 cycles while streaming bundles B0, B1, B2. -> B0 held in OUT, B1 in SKID, enq_ready=0 so B2 stalls. On deq_ready=1, B0 then B1 then B2 emerge in order, with no gap after the stall.
- With the macro, way 0 dest 0 regwrite=1 and way 1 A=0. -> dep[1]=0, last[0]=0. Without the macro -> dep[1]=1 sel=0, last[0]=1.
- OUT and SKID full, then assert flush for one cycle. -> deq_valid=0 and enq_ready=1 the next cycle. A bundle offered during flush never appears.
- nRST pulsed low asynchronously between edges while both entries are full. -> deq_valid=0 and enq_ready=1 immediately, with all payload outputs 0.
